// File: rtl/mux_arb_pkg.sv
// Shared constants and FSM encoding for the 8-channel MUX/DMX arbiter.
package mux_arb_pkg;

  localparam int N_CH   = 8;
  localparam int ADDR_W = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

endpackage

// File: rtl/rr_priority_enc.sv
// Combinational round-robin picker: first set request above ptr, wrapping.
module rr_priority_enc
  import mux_arb_pkg::*;
(
  input  logic [N_CH-1:0]   req,
  input  logic [ADDR_W-1:0] ptr,
  output logic              valid,
  output logic [ADDR_W-1:0] idx
);

  logic [ADDR_W-1:0] shift;
  logic [2*N_CH-1:0] doubled;
  logic [N_CH-1:0]   rot;
  logic [ADDR_W-1:0] low;

  // Rotating by ptr+1 puts the channel just after the previous owner at bit 0.
  assign shift   = ptr + ADDR_W'(1);
  assign doubled = {req, req} >> shift;
  assign rot     = doubled[N_CH-1:0];

  always_comb begin
    low = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) low = ADDR_W'(i);
    end
  end

  assign valid = |req;
  assign idx   = low + shift;

endmodule

// File: rtl/mux_channel_arbiter.sv
// Round-robin burst arbiter driving the shared MUX/DMX channel address,
// with a one-cycle guard gap between grants.
module mux_channel_arbiter #(
  parameter int N_CH    = 8,
  parameter int ADDR_W  = 3,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    req,
  input  logic [BURST_W-1:0] burst_len,
  output logic [N_CH-1:0]    grant,
  output logic [ADDR_W-1:0]  addr,
  output logic               busy,
  output logic               last
);
  import mux_arb_pkg::ST_IDLE;
  import mux_arb_pkg::ST_GRANT;
  import mux_arb_pkg::ST_GUARD;

  logic [1:0]         state;
  logic [ADDR_W-1:0]  ptr;
  logic [BURST_W-1:0] cnt;
  logic               win_valid;
  logic [ADDR_W-1:0]  win_idx;

  rr_priority_enc u_enc (
    .req   (req),
    .ptr   (ptr),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // The owner releasing its request ends the burst in the same cycle.
  assign busy = (state == ST_GRANT);
  assign last = busy && ((cnt == '0) || !req[addr]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      grant <= '0;
      addr  <= '0;
      ptr   <= ADDR_W'(N_CH - 1);
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_GUARD: begin
          grant <= '0;
          if (win_valid) begin
            grant <= N_CH'(1) << win_idx;
            addr  <= win_idx;
            ptr   <= win_idx;
            cnt   <= burst_len;
            state <= ST_GRANT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (last) begin
            grant <= '0;
            state <= ST_GUARD;
          end else begin
            cnt <= cnt - BURST_W'(1);
          end
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_channel_arbiter.sv
// Bench for mux_channel_arbiter: directed vector table, a reset-mid-burst
// sequence, and randomized traffic against a behavioural model.
module tb_mux_channel_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic [3:0] burst_len = '0;
  logic [7:0] grant;
  logic [2:0] addr;
  logic       busy;
  logic       last;

  int n_vec  = 0;
  int n_miss = 0;

  mux_channel_arbiter #(.N_CH(8), .ADDR_W(3), .BURST_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .burst_len (burst_len),
    .grant     (grant),
    .addr      (addr),
    .busy      (busy),
    .last      (last)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst_before;
    logic [7:0] req;
    logic [3:0] bl;
    logic [7:0] g;
    logic [2:0] a;
    logic       b;
    logic       l;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: owner channel (-1 = none), cycles used vs allowed.
  int m_owner, m_used, m_limit, m_addr, m_ptr;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void add(bit r, logic [7:0] q, logic [3:0] b,
                              logic [7:0] g, logic [2:0] a, logic bz, logic l);
    vec_t v;
    v.rst_before = r; v.req = q; v.bl = b; v.g = g; v.a = a; v.b = bz; v.l = l;
    tbl.push_back(v);
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_used = 0; m_limit = 0; m_addr = 0; m_ptr = 7;
  endfunction

  function automatic bit model_last();
    return (m_owner >= 0) && ((m_used == m_limit) || !req[m_owner]);
  endfunction

  function automatic void model_step();
    int w;
    bit found;
    if (m_owner >= 0) begin
      if (model_last()) m_owner = -1;
      else m_used++;
    end else begin
      found = 0;
      w = 0;
      for (int k = 1; k <= 8; k++) begin
        if (!found && req[(m_ptr + k) % 8]) begin
          found = 1;
          w = (m_ptr + k) % 8;
        end
      end
      if (found) begin
        m_owner = w; m_addr = w; m_ptr = w; m_used = 0; m_limit = int'(burst_len);
      end
    end
  endfunction

  function automatic void check_invariants();
    chk("onehot0", 32'($onehot0(grant)), 32'd1);
    chk("busy_vs_grant", 32'(busy), 32'(|grant));
  endfunction

  function automatic void check_model();
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    chk("rnd_grant", 32'(grant), 32'(eg));
    chk("rnd_addr", 32'(addr), 32'(m_addr));
    chk("rnd_busy", 32'(busy), 32'(m_owner >= 0));
    chk("rnd_last", 32'(last), 32'(model_last()));
    check_invariants();
  endfunction

  task automatic apply(input logic [7:0] r, input logic [3:0] b);
    @(negedge clk);
    req = r;
    burst_len = b;
    #1;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    model_reset();
    #2;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_addr", 32'(addr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();

    // single request, burst_len=3; burst_len changes mid-grant are ignored
    add(1, 8'h08, 4'd3, 8'h00, 3'd0, 1'b0, 1'b0);
    add(0, 8'h08, 4'd9, 8'h08, 3'd3, 1'b1, 1'b0);
    add(0, 8'h08, 4'd9, 8'h08, 3'd3, 1'b1, 1'b0);
    add(0, 8'h08, 4'd9, 8'h08, 3'd3, 1'b1, 1'b0);
    add(0, 8'h08, 4'd3, 8'h08, 3'd3, 1'b1, 1'b1);
    add(0, 8'h08, 4'd3, 8'h00, 3'd3, 1'b0, 1'b0);
    add(0, 8'h08, 4'd3, 8'h08, 3'd3, 1'b1, 1'b0);
    // round robin over all channels, single-cycle bursts
    add(1, 8'hFF, 4'd0, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      add(0, 8'hFF, 4'd0, 8'd1 << (i % 8), 3'(i % 8), 1'b1, 1'b1);
      add(0, 8'hFF, 4'd0, 8'h00, 3'(i % 8), 1'b0, 1'b0);
    end
    // early release of channel 0 on its third grant cycle
    add(1, 8'h21, 4'd15, 8'h00, 3'd0, 1'b0, 1'b0);
    add(0, 8'h21, 4'd15, 8'h01, 3'd0, 1'b1, 1'b0);
    add(0, 8'h21, 4'd15, 8'h01, 3'd0, 1'b1, 1'b0);
    add(0, 8'h20, 4'd15, 8'h01, 3'd0, 1'b1, 1'b1);
    add(0, 8'h20, 4'd15, 8'h00, 3'd0, 1'b0, 1'b0);
    add(0, 8'h20, 4'd15, 8'h20, 3'd5, 1'b1, 1'b0);
    // wrap-around from ptr=6
    add(1, 8'h40, 4'd0, 8'h00, 3'd0, 1'b0, 1'b0);
    add(0, 8'h41, 4'd0, 8'h40, 3'd6, 1'b1, 1'b1);
    add(0, 8'h41, 4'd0, 8'h00, 3'd6, 1'b0, 1'b0);
    add(0, 8'h41, 4'd0, 8'h01, 3'd0, 1'b1, 1'b1);

    foreach (tbl[i]) begin
      if (tbl[i].rst_before) do_reset();
      apply(tbl[i].req, tbl[i].bl);
      chk("tbl_grant", 32'(grant), 32'(tbl[i].g));
      chk("tbl_addr", 32'(addr), 32'(tbl[i].a));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].b));
      chk("tbl_last", 32'(last), 32'(tbl[i].l));
      check_invariants();
      finish_cycle();
    end

    // reset asserted in the second cycle of a 16-cycle burst on channel 4
    do_reset();
    apply(8'h10, 4'd15);
    finish_cycle();
    apply(8'h10, 4'd15);
    chk("mid_grant_c1", 32'(grant), 32'h10);
    finish_cycle();
    apply(8'h10, 4'd15);
    chk("mid_grant_c2", 32'(grant), 32'h10);
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_addr", 32'(addr), 32'h0);
    chk("mid_rst_last", 32'(last), 32'h0);
    rst = 1'b0;
    req = 8'h90;
    finish_cycle();
    apply(8'h90, 4'd15);
    chk("post_rst_grant", 32'(grant), 32'h10);
    chk("post_rst_addr", 32'(addr), 32'd4);
    finish_cycle();

    // randomized traffic against the model, with occasional async resets
    do_reset();
    for (int c = 0; c < 800; c++) begin
      logic [7:0] r;
      r = req;
      if ($urandom_range(3) == 0) r = 8'($urandom & $urandom);
      apply(r, 4'($urandom_range(15)));
      check_model();
      if ($urandom_range(99) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        check_model();
        rst = 1'b0;
      end
      finish_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mux_channel_arbiter.md
# mux_channel_arbiter

Round-robin arbiter and sequencer for the shared 8-channel MUX/DMX datapath. Eight requesters compete for the single routed channel. The block selects one requester and drives the shared 3-bit `addr` for a bounded burst. It then inserts a one-cycle guard gap before re-arbitrating, so `addr` never changes while data is routed. The block sits between the requester logic and the `addr` input shared by the MUX and DMX instances.

## Interface

Parameters:
- `N_CH`, default 8: number of requesters. Fixed at 8 to match the 3-bit `addr`.
- `ADDR_W`, default 3: width of `addr`.
- `BURST_W`, default 4: width of `burst_len` and of the internal burst counter.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 8: per-channel request, level-sensitive. A requester holds it high for as long as it wants the channel.
- `burst_len` in `BURST_W`: maximum grant length minus 1. Sampled only on the arbitration edge.
- `grant` out 8: one-hot grant, registered. All zeros when no channel is granted.
- `addr` out `ADDR_W`: index of the granted or last-granted channel, registered. Drives MUX/DMX `addr`.
- `busy` out 1: high while in GRANT.
- `last` out 1: high during the final cycle of a grant.

## Operation

- **States:** IDLE, GRANT, GUARD.
- **Reset values:** state=IDLE, `grant`=0, `addr`=0, `busy`=0, `last`=0, rr pointer `ptr`=7, counter `cnt`=0.
- **IDLE**
  - If any `req` bit is high, pick the winner `w`, then set `grant`=1<<`w`, `addr`=`w`, `ptr`=`w`, `cnt`=`burst_len`, and go to GRANT.
  - Otherwise stay in IDLE.
- **Winner selection:** the first set `req` bit found scanning from `ptr`+1 upward, wrapping modulo 8. After reset, channel 0 has the highest priority.
- **GRANT**
  - `busy`=1.
  - `last`=1 when `cnt`==0 or `req[addr]`==0. This is decoded from registered state and the current `req`.
  - If `last`: clear `grant` and go to GUARD.
  - Otherwise: `cnt`←`cnt`−1.
- **GUARD**
  - `grant`=0 and `addr` holds its value.
  - Arbitration is identical to IDLE. With pending requests, go straight to GRANT. Otherwise go to IDLE.
- **Arithmetic:** `cnt` is unsigned `BURST_W` bits and never wraps, because it is only decremented while nonzero. Maximum burst is 2^`BURST_W` cycles (16).
- **Boundary conditions**
  - `req` all zero: remain in IDLE. `addr` keeps its last value.
  - `burst_len`=0: grant lasts exactly 1 cycle.
  - Owner drops `req` mid-burst: the cycle in which the drop is sampled is the final grant cycle (`last`=1).
  - A single requester holding `req` continuously is re-granted after each guard cycle.
  - Changes to `req` from non-owners during GRANT are ignored until the next arbitration.
  - `rst` asserted mid-burst: `grant` clears immediately (asynchronous), all registers return to their reset values, and `ptr` returns to 7.
  - `burst_len` changes during GRANT have no effect on the current burst.

## Timing

- Arbitration latency is 1 cycle. If `req` is sampled high at edge t in IDLE, `grant` and `addr` are valid after edge t.
- A burst of length L=`burst_len`+1 with `req` held gives exactly L consecutive cycles of `grant` high.
- The gap between grants is exactly 1 cycle (GUARD) whenever requests are pending.
- `addr` is stable for the full grant and the following GUARD cycle. It changes only on the edge that enters GRANT.
- `grant` never has more than one bit set, including across a reset edge.

## Structure

- **Package `mux_arb_pkg`:** holds `N_CH`, `ADDR_W`, and the state encoding (IDLE=2'd0, GRANT=2'd1, GUARD=2'd2).
- **Sub-module `rr_priority_enc`:** purely combinational.
  - Inputs: `req[7:0]` and `ptr[2:0]`.
  - Outputs: `valid` and `idx[2:0]`.
  - Implementation: rotate right by `ptr`+1, priority-encode the lowest set bit, then add the rotation back modulo 8.
- **Top level:** contains the FSM, `cnt`, `ptr`, and the output registers.

## Test plan

- **Reset and single request:** after `rst`, set `req`=8'h08 and `burst_len`=3. Expect `grant`=8'h08 and `addr`=3 for 4 cycles, `last` high on the 4th cycle, then 1 GUARD cycle, then re-grant of channel 3.
- **Round-robin fairness:** set `req`=8'hFF and `burst_len`=0. Expect grant order 0,1,2,…,7,0, with one grant cycle and one guard cycle each.
- **Early release:** set `req`=8'h21 and `burst_len`=15, and drop `req[0]` on the 3rd grant cycle. Expect `last` on that cycle, then GUARD, then `grant`=8'h20 with `addr`=5.
- **Wrap-around:** force `ptr`=6 via a prior grant of channel 6, then set `req`=8'h41. Expect the next winner to be channel 0, not channel 6.
- **Reset mid-burst:** assert `rst` in the 2nd cycle of a 16-cycle burst on channel 4. Expect `grant`=0, `busy`=0, and `addr`=0 with no clock edge. After release with `req`=8'h90, expect channel 4 to win (ptr=7).
- **Invariant checks every cycle:** `grant` is one-hot or zero, `busy` equals `|grant`, and `addr` is unchanged during GRANT and GUARD.
